// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: hunts a serial preamble, shifts in one CLB config frame, checks
// even parity and commits the frame to the parallel configuration word.
module clb_cfg_loader #(
    parameter int CFG_W = 37,
    parameter int PRE_W = 8,
    parameter logic [PRE_W-1:0] PREAMBLE = 8'hB5
) (
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DIN_EN,
    input  logic             RESTART,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VLD,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);
    localparam int CW = $clog2(CFG_W);
    localparam logic [CW-1:0] LAST = CW'(CFG_W - 1);
    localparam logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(37'h15_0008_B038);
    localparam logic [1:0] SYNC = 2'd0, LOAD = 2'd1, PAR = 2'd2, DONE_ST = 2'd3;

    logic [1:0]       state;
    logic [PRE_W-1:0] pre;
    logic [CFG_W-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic [PRE_W-1:0] pre_nxt;

    assign pre_nxt = {pre[PRE_W-2:0], DIN};
    assign BUSY = (state == LOAD) || (state == PAR);

    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state   <= SYNC;
            pre     <= '0;
            shadow  <= '0;
            cnt     <= '0;
            CFG     <= CFG_DEFAULT;
            CFG_VLD <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            CFG_VLD <= 1'b0;
            if (RESTART) begin
                state  <= SYNC;
                pre    <= '0;
                shadow <= '0;
                cnt    <= '0;
                DONE   <= 1'b0;
                ERR    <= 1'b0;
            end else if (DIN_EN) begin
                case (state)
                    SYNC: begin
                        if (pre_nxt == PREAMBLE) begin
                            state <= LOAD;
                            cnt   <= '0;
                            pre   <= '0;
                        end else begin
                            pre <= pre_nxt;
                        end
                    end
                    LOAD: begin
                        shadow <= {shadow[CFG_W-2:0], DIN};
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) state <= PAR;
                    end
                    PAR: begin
                        // even parity over frame plus parity bit must be zero
                        if (^{shadow, DIN}) begin
                            ERR   <= 1'b1;
                            pre   <= '0;
                            state <= SYNC;
                        end else begin
                            CFG     <= shadow;
                            CFG_VLD <= 1'b1;
                            DONE    <= 1'b1;
                            ERR     <= 1'b0;
                            state   <= DONE_ST;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: directed scenario tests for the serial CLB configuration loader.
module tb_clb_cfg_loader;
    localparam logic [36:0] DEF = 37'h15_0008_B038;
    localparam logic [36:0] FA  = 37'h01_2345_6789;
    localparam logic [36:0] FB  = 37'h1F_FFFF_FFFF;
    localparam logic [36:0] FC  = 37'h00_00B5_B500;

    logic K = 1'b0, RST = 1'b0, DIN = 1'b0, DIN_EN = 1'b0, RESTART = 1'b0;
    logic [36:0] CFG;
    logic CFG_VLD, BUSY, DONE, ERR;
    int errors = 0, checks = 0;
    int vld_cnt, busy_cnt, edge_n, vld_at;

    clb_cfg_loader dut (
        .K(K), .RST(RST), .DIN(DIN), .DIN_EN(DIN_EN), .RESTART(RESTART),
        .CFG(CFG), .CFG_VLD(CFG_VLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 K = ~K;

    task automatic clr_cnt();
        vld_cnt = 0;
        busy_cnt = 0;
        edge_n = 0;
        vld_at = 0;
    endtask

    task automatic send_bit(input logic b, input logic en, input logic rs);
        @(negedge K);
        DIN = b;
        DIN_EN = en;
        RESTART = rs;
        @(posedge K);
        #1;
        edge_n++;
        if (CFG_VLD) begin
            vld_cnt++;
            vld_at = edge_n;
        end
        if (BUSY) busy_cnt++;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input logic gap);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i], 1'b1, 1'b0);
            if (gap) send_bit(~v[i], 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [36:0] f, input logic p, input logic gap);
        send_bits(64'hB5, 8, gap);
        send_bits({27'b0, f}, 37, gap);
        send_bits({63'b0, p}, 1, gap);
    endtask

    task automatic test_reset();
        @(posedge K);
        #2 RST = 1'b1;
        #1;
        checks++; if (CFG !== DEF) begin errors++; $display("FAIL reset_cfg got=%h exp=%h", CFG, DEF); end
        checks++; if ({CFG_VLD, BUSY, DONE, ERR} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {CFG_VLD, BUSY, DONE, ERR}); end
        @(negedge K) RST = 1'b0;
    endtask

    task automatic test_good_load();
        clr_cnt();
        send_frame(FA, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL good_vld_cnt got=%0d exp=1", vld_cnt); end
        checks++; if (vld_at !== 46) begin errors++; $display("FAIL good_latency got=%0d exp=46", vld_at); end
        checks++; if (busy_cnt !== 38) begin errors++; $display("FAIL good_busy_cnt got=%0d exp=38", busy_cnt); end
        checks++; if (CFG !== FA) begin errors++; $display("FAIL good_cfg got=%h exp=%h", CFG, FA); end
        checks++; if ({DONE, ERR, CFG_VLD} !== 3'b100) begin errors++; $display("FAIL good_flags got=%b exp=100", {DONE, ERR, CFG_VLD}); end
    endtask

    task automatic test_parity_fail();
        @(negedge K) RST = 1'b1;
        @(negedge K) RST = 1'b0;
        clr_cnt();
        send_frame(FA, 1'b0, 1'b0);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL par_err got=%b exp=1", ERR); end
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL par_vld_cnt got=%0d exp=0", vld_cnt); end
        checks++; if (CFG !== DEF) begin errors++; $display("FAIL par_cfg got=%h exp=%h", CFG, DEF); end
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL par_busy_done got=%b exp=00", {BUSY, DONE}); end
        clr_cnt();
        send_frame(FA, 1'b1, 1'b0);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL par_retry_vld got=%0d exp=1", vld_cnt); end
        checks++; if (CFG !== FA) begin errors++; $display("FAIL par_retry_cfg got=%h exp=%h", CFG, FA); end
        checks++; if ({DONE, ERR} !== 2'b10) begin errors++; $display("FAIL par_retry_flags got=%b exp=10", {DONE, ERR}); end
    endtask

    task automatic test_gaps();
        send_bit(1'b0, 1'b0, 1'b1);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL gap_restart_done got=%b exp=0", DONE); end
        clr_cnt();
        send_bits(64'b101, 3, 1'b1);
        send_frame(FB, 1'b1, 1'b1);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL gap_vld_cnt got=%0d exp=1", vld_cnt); end
        checks++; if (CFG !== FB) begin errors++; $display("FAIL gap_cfg got=%h exp=%h", CFG, FB); end
        checks++; if (busy_cnt !== 76) begin errors++; $display("FAIL gap_busy_cnt got=%0d exp=76", busy_cnt); end
    endtask

    task automatic test_restart();
        send_bit(1'b0, 1'b0, 1'b1);
        clr_cnt();
        send_bits(64'hB5, 8, 1'b0);
        send_bits({44'b0, FA[36:17]}, 20, 1'b0);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rs_busy_mid got=%b exp=1", BUSY); end
        send_bit(1'b1, 1'b1, 1'b1);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rs_busy_drop got=%b exp=0", BUSY); end
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL rs_vld_cnt got=%0d exp=0", vld_cnt); end
        checks++; if (CFG !== FB) begin errors++; $display("FAIL rs_cfg_hold got=%h exp=%h", CFG, FB); end
        clr_cnt();
        send_frame(FC, 1'b0, 1'b0);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL rs_reload_vld got=%0d exp=1", vld_cnt); end
        checks++; if (CFG !== FC) begin errors++; $display("FAIL embedded_pre_cfg got=%h exp=%h", CFG, FC); end
        send_bit(1'b0, 1'b0, 1'b1);
        clr_cnt();
        send_bits(64'hB5, 8, 1'b0);
        send_bits({27'b0, FA}, 37, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL rs_par_edge_vld got=%0d exp=0", vld_cnt); end
        checks++; if (CFG !== FC) begin errors++; $display("FAIL rs_par_edge_cfg got=%h exp=%h", CFG, FC); end
        checks++; if ({BUSY, DONE, ERR} !== 3'b000) begin errors++; $display("FAIL rs_par_edge_flags got=%b exp=000", {BUSY, DONE, ERR}); end
    endtask

    task automatic test_done_st();
        send_frame(FC, 1'b0, 1'b0);
        checks++; if ({DONE, CFG} !== {1'b1, FC}) begin errors++; $display("FAIL ds_commit got=%b/%h exp=1/%h", DONE, CFG, FC); end
        clr_cnt();
        send_frame(FA, 1'b1, 1'b0);
        checks++; if (vld_cnt !== 0 || busy_cnt !== 0) begin errors++; $display("FAIL ds_ignore got=vld%0d/busy%0d exp=vld0/busy0", vld_cnt, busy_cnt); end
        checks++; if ({DONE, CFG} !== {1'b1, FC}) begin errors++; $display("FAIL ds_hold got=%b/%h exp=1/%h", DONE, CFG, FC); end
        send_bit(1'b0, 1'b0, 1'b1);
        clr_cnt();
        send_frame(FA, 1'b1, 1'b0);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL ds_reload_vld got=%0d exp=1", vld_cnt); end
        checks++; if (CFG !== FA) begin errors++; $display("FAIL ds_reload_cfg got=%h exp=%h", CFG, FA); end
    endtask

    task automatic test_rst_mid_frame();
        send_bit(1'b0, 1'b0, 1'b1);
        send_bits(64'hB5, 8, 1'b0);
        send_bits(64'h3FF, 10, 1'b0);
        #2 RST = 1'b1;
        #1;
        checks++; if (CFG !== DEF) begin errors++; $display("FAIL rst_mid_cfg got=%h exp=%h", CFG, DEF); end
        checks++; if ({BUSY, DONE, ERR, CFG_VLD} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got=%b exp=0000", {BUSY, DONE, ERR, CFG_VLD}); end
        @(negedge K) RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_parity_fail();
        test_gaps();
        test_restart();
        test_done_st();
        test_rst_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
